// File: rtl/compare_serial.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, stopping at the first differing chunk.
module compare_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             ga,
  output logic             eq,
  output logic             la,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("compare_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             smode_q, smode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ga_q, ga_d, eq_q, eq_d, la_q, la_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             flip_msb, chunk_ne, accept;

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
  // DONE); busy stays high until the result lands, then done pulses for one
  // cycle with ga/eq/la/cycles already valid and held until the next done.
  assign accept = start && (state_q != S_CMP);

  // Flipping the top chunk's MSB maps two's-complement order onto unsigned order.
  assign a_sh     = a_q >> (idx_q * CHUNK);
  assign b_sh     = b_q >> (idx_q * CHUNK);
  assign flip_msb = smode_q && (idx_q == TOP_IDX);
  assign chunk_a  = a_sh[CHUNK-1:0] ^ (flip_msb ? MSB_MASK : '0);
  assign chunk_b  = b_sh[CHUNK-1:0] ^ (flip_msb ? MSB_MASK : '0);
  assign chunk_ne = (chunk_a != chunk_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      smode_q  <= 1'b0;
      idx_q    <= '0;
      ga_q     <= 1'b0;
      eq_q     <= 1'b0;
      la_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      smode_q  <= smode_d;
      idx_q    <= idx_d;
      ga_q     <= ga_d;
      eq_q     <= eq_d;
      la_q     <= la_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CMP;
      S_CMP:   if (chunk_ne || (idx_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = start ? S_CMP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    smode_d  = smode_q;
    idx_d    = idx_q;
    ga_d     = ga_q;
    eq_d     = eq_q;
    la_d     = la_q;
    cycles_d = cycles_q;
    if (accept) begin
      a_d     = operand_a;
      b_d     = operand_b;
      smode_d = signed_mode;
      idx_d   = TOP_IDX;
    end else if (state_q == S_CMP) begin
      if (chunk_ne) begin
        ga_d     = (chunk_a > chunk_b);
        la_d     = (chunk_a < chunk_b);
        eq_d     = 1'b0;
        cycles_d = CW'(NCHUNK - int'(idx_q));
      end else if (idx_q == '0) begin
        ga_d     = 1'b0;
        la_d     = 1'b0;
        eq_d     = 1'b1;
        cycles_d = CW'(NCHUNK);
      end else begin
        idx_d = idx_q - IW'(1);
      end
    end
  end

  always_comb begin
    busy   = (state_q == S_CMP);
    done   = (state_q == S_DONE);
    ga     = ga_q;
    eq     = eq_q;
    la     = la_q;
    cycles = cycles_q;
  end

endmodule

// File: tb/tb_compare_serial.sv
// Bench for compare_serial: directed 32/8 cases plus randomized 16/4 pairs,
// checked against a full-width arithmetic reference model.
module tb_compare_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s32_start, s32_sm, s32_busy, s32_done, s32_ga, s32_eq, s32_la;
  logic [31:0] s32_a, s32_b;
  logic [2:0]  s32_cyc;
  logic        s16_start, s16_sm, s16_busy, s16_done, s16_ga, s16_eq, s16_la;
  logic [15:0] s16_a, s16_b;
  logic [2:0]  s16_cyc;

  compare_serial #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(s32_start), .signed_mode(s32_sm),
    .operand_a(s32_a), .operand_b(s32_b), .busy(s32_busy), .done(s32_done),
    .ga(s32_ga), .eq(s32_eq), .la(s32_la), .cycles(s32_cyc)
  );

  compare_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(s16_start), .signed_mode(s16_sm),
    .operand_a(s16_a), .operand_b(s16_b), .busy(s16_busy), .done(s16_done),
    .ga(s16_ga), .eq(s16_eq), .la(s16_la), .cycles(s16_cyc)
  );

  // sel picks the instance under test: 0 = 32/8, 1 = 16/4
  int          sel;
  logic        o_busy, o_done, o_ga, o_eq, o_la;
  logic [2:0]  o_cyc;
  always_comb begin
    if (sel == 0) {o_busy, o_done, o_ga, o_eq, o_la, o_cyc} = {s32_busy, s32_done, s32_ga, s32_eq, s32_la, s32_cyc};
    else          {o_busy, o_done, o_ga, o_eq, o_la, o_cyc} = {s16_busy, s16_done, s16_ga, s16_eq, s16_la, s16_cyc};
  end

  int          n_total = 0;
  int          n_bad   = 0;
  logic [13:0] exp_q[$];    // {latency[7:0], cycles[2:0], ga, eq, la}
  logic [5:0]  last_exp[2]; // {cycles, ga, eq, la} of the last result per instance

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic sm, input int w);
    longint m, sa, sb;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  function automatic int ref_cycles(input logic [31:0] a, input logic [31:0] b,
                                    input int w, input int ch);
    logic [31:0] m;
    int          lo;
    m = (32'd1 << ch) - 1;
    for (int k = 0; k < w / ch; k++) begin
      lo = w - (k + 1) * ch;
      if ((((a >> lo) ^ (b >> lo)) & m) != 0) return k + 1;
    end
    return w / ch;
  endfunction

  task automatic set_inputs(input logic st, input logic [31:0] a, input logic [31:0] b, input logic sm);
    if (sel == 0) begin
      s32_start = st; s32_a = a; s32_b = b; s32_sm = sm;
    end else begin
      s16_start = st; s16_a = a[15:0]; s16_b = b[15:0]; s16_sm = sm;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic sm);
    int         w, ch, c;
    logic [2:0] f;
    w  = (sel == 0) ? 32 : 16;
    ch = (sel == 0) ? 8 : 4;
    f  = ref_flags(a, b, sm, w);
    c  = ref_cycles(a, b, w, ch);
    exp_q.push_back({8'(c + 1), 3'(c), f});
  endtask

  // Called just after the start-sampling edge; follows the comparison to done.
  task automatic collect(input bit mid_pulse, input bit chain,
                         input logic [31:0] a2, input logic [31:0] b2, input logic sm2);
    logic [13:0] e;
    int          n;
    bit          held;
    e    = exp_q.pop_front();
    n    = 0;
    held = 1;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) set_inputs(mid_pulse, $urandom, $urandom, 1'($urandom));
      if (n == 2) set_inputs(1'b0, $urandom, $urandom, 1'($urandom));
      if (o_done || n > 12) break;
      if (!o_busy || {o_cyc, o_ga, o_eq, o_la} != last_exp[sel]) held = 0;
    end
    chk("latency", n, 32'(e[13:6]));
    chk("busy_hold", 32'(held), 1);
    chk("flags", {o_ga, o_eq, o_la}, 32'(e[2:0]));
    chk("cycles", o_cyc, 32'(e[5:3]));
    chk("busy_at_done", o_busy, 0);
    last_exp[sel] = e[5:0];
    if (chain) begin
      set_inputs(1'b1, a2, b2, sm2);
    end else begin
      @(negedge clk);
      chk("done_single", {o_done, o_busy}, 2'b00);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sm, input bit mid);
    push_exp(a, b, sm);
    @(negedge clk);
    set_inputs(1'b1, a, b, sm);
    @(posedge clk);
    collect(mid, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          seen;
    sel = 0;
    s32_start = 0; s32_sm = 0; s32_a = 0; s32_b = 0;
    s16_start = 0; s16_sm = 0; s16_a = 0; s16_b = 0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset32", {s32_busy, s32_done, s32_ga, s32_eq, s32_la, s32_cyc}, 0);
    chk("reset16", {s16_busy, s16_done, s16_ga, s16_eq, s16_la, s16_cyc}, 0);
    rst = 1'b0;

    run_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    run_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_one(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    run_one(32'h1234_5679, 32'h1234_5678, 1'b0, 1'b0);
    run_one(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_one(32'h7F00_0000, 32'h8000_0000, 1'b1, 1'b1);
    run_one(32'h0012_0000, 32'h0034_0000, 1'b0, 1'b0);

    // Back-to-back: start in the DONE cycle, plus an ignored start mid-CMP.
    push_exp(32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0);
    push_exp(32'h0000_0100, 32'h0000_0200, 1'b1);
    @(negedge clk);
    set_inputs(1'b1, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0);
    @(posedge clk);
    collect(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 1'b1);
    @(posedge clk);
    collect(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    // Asynchronous abort in the middle of a comparison.
    @(negedge clk);
    set_inputs(1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_inputs(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_abort", {s32_busy, s32_done, s32_ga, s32_eq, s32_la, s32_cyc}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s32_done) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    run_one(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);

    // Randomized 16/4 instance, both modes.
    sel = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFFFF;
      case ($urandom_range(0, 3))
        0:       rb = $urandom & 32'hFFFF;
        1:       rb = ra;
        2:       rb = ra ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: rb = ra ^ 32'($urandom_range(1, 15));
      endcase
      run_one(ra, rb, 1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
